// File: rtl/senior_io_hs.sv
// Handshaked I/O port unit: registers one core read/write, holds it on the external bus
// until acknowledged (or a bounded wait expires), and stalls the core meanwhile.
module senior_io_hs #(
  parameter int nat_w = 16,
  parameter int addr_w = 8,
  parameter int TIMEOUT = 15,
  parameter logic [nat_w-1:0] RD_ERR_VAL = {nat_w{1'b1}}
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [addr_w-1:0] addr_i,
  input  logic [nat_w-1:0]  io_intdata_i,
  output logic [nat_w-1:0]  io_intdata_o,
  output logic              stall_o,
  output logic              err_o,
  input  logic              err_clr_i,
  input  logic [nat_w-1:0]  io_data_i,
  input  logic              io_ack_i,
  output logic              io_rd_strobe_o,
  output logic              io_wr_strobe_o,
  output logic [nat_w-1:0]  io_data_o,
  output logic [addr_w-1:0] io_addr_o
);

  localparam int cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nx;

  logic [cnt_w-1:0]  cnt, cnt_d;
  logic              dir_wr, dir_wr_d;
  logic              rd_strobe_d, wr_strobe_d, stall_d, err_d;
  logic [nat_w-1:0]  intdata_d, data_d;
  logic [addr_w-1:0] addr_d;

  logic req_ok, req_bad, timeout_hit;

  assign req_ok      = rd_req_i ^ wr_req_i;
  assign req_bad     = rd_req_i & wr_req_i;
  assign timeout_hit = (state == ACCESS) && !io_ack_i && (cnt == last_cnt);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_ok) state_nx = ACCESS;
      ACCESS:  if (io_ack_i || cnt == last_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, so the bus strobes
  // and stall appear one cycle behind the state that produced them.
  always_comb begin
    rd_strobe_d = (state == ACCESS) && !dir_wr;
    wr_strobe_d = (state == ACCESS) && dir_wr;
    stall_d     = (state == ACCESS);
    intdata_d   = io_intdata_o;
    addr_d      = io_addr_o;
    data_d      = io_data_o;
    dir_wr_d    = dir_wr;
    cnt_d       = cnt;
    err_d       = err_o;
    if (err_clr_i) err_d = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          addr_d   = addr_i;
          data_d   = io_intdata_i;
          dir_wr_d = wr_req_i;
          cnt_d    = '0;
        end
        if (req_bad) err_d = 1'b1;
      end
      ACCESS: begin
        if (io_ack_i) begin
          if (!dir_wr) intdata_d = io_data_i;
        end else begin
          cnt_d = cnt + 1'b1;
          if (timeout_hit) begin
            err_d = 1'b1;
            if (!dir_wr) intdata_d = RD_ERR_VAL;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      io_rd_strobe_o <= 1'b0;
      io_wr_strobe_o <= 1'b0;
      stall_o        <= 1'b0;
      err_o          <= 1'b0;
      io_intdata_o   <= '0;
      io_addr_o      <= '0;
      io_data_o      <= '0;
      dir_wr         <= 1'b0;
      cnt            <= '0;
    end else begin
      io_rd_strobe_o <= rd_strobe_d;
      io_wr_strobe_o <= wr_strobe_d;
      stall_o        <= stall_d;
      err_o          <= err_d;
      io_intdata_o   <= intdata_d;
      io_addr_o      <= addr_d;
      io_data_o      <= data_d;
      dir_wr         <= dir_wr_d;
      cnt            <= cnt_d;
    end
  end

endmodule

// File: tb/tb_senior_io_hs.sv
// Bench for senior_io_hs: scenario tasks drive core requests and peripheral acks, and
// read results are checked against an expected queue when each transfer retires.
module tb_senior_io_hs;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] intdata;
  logic        stall;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] ext_data = '0;
  logic        ack = 1'b0;
  logic        rd_stb;
  logic        wr_stb;
  logic [15:0] bus_data;
  logic [7:0]  bus_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_rd = '0;

  senior_io_hs #(.nat_w(16), .addr_w(8), .TIMEOUT(TIMEOUT), .RD_ERR_VAL(16'hFFFF)) dut (
    .clk_i(clk), .reset_i(reset), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .addr_i(addr), .io_intdata_i(wdata), .io_intdata_o(intdata), .stall_o(stall),
    .err_o(err), .err_clr_i(err_clr), .io_data_i(ext_data), .io_ack_i(ack),
    .io_rd_strobe_o(rd_stb), .io_wr_strobe_o(wr_stb), .io_data_o(bus_data),
    .io_addr_o(bus_addr)
  );

  always #5 clk = ~clk;

  // One transfer; called at a falling edge. k = index of the acked ACCESS cycle
  // (0 = first), k >= TIMEOUT means no ack. clr_at pulses err_clr at the same index.
  task automatic xfer(input logic is_wr, input logic [7:0] a, input logic [15:0] d,
                      input int k, input logic exp_err, input int clr_at, input string name);
    int hi, st, first, exp_hi;
    logic done, bus_bad, noack;
    logic [15:0] exp_v, got_v;
    noack  = (k >= TIMEOUT);
    exp_hi = noack ? TIMEOUT : k + 1;
    exp_v  = is_wr ? model_rd : (noack ? 16'hFFFF : d);
    if (!is_wr) model_rd = exp_v;
    exp_q.push_back(exp_v);
    rd_req = !is_wr; wr_req = is_wr; addr = a; wdata = d;
    ext_data = is_wr ? 16'(~d) : d;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; addr = 8'(~a); wdata = 16'h0;
    ack = (k == 0); err_clr = (clr_at == 0);
    hi = 0; st = 0; first = -1; done = 1'b0; bus_bad = 1'b0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      ack = (i == k); err_clr = (i == clr_at);
      if (is_wr ? wr_stb : rd_stb) begin
        hi++;
        if (first < 0) first = i;
        if (bus_addr !== a || (is_wr && bus_data !== d)) bus_bad = 1'b1;
      end else if (hi > 0) done = 1'b1;
      if (is_wr ? rd_stb : wr_stb) bus_bad = 1'b1;
      if (stall) st++;
    end
    ack = 1'b0; err_clr = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL %s retire: not retired within bound", name);
    end
    n_cmp++;
    if (first !== 1) begin
      n_bad++; $display("FAIL %s latency: strobe first high at cycle %0d, required 1", name, first);
    end
    n_cmp++;
    if (hi !== exp_hi) begin
      n_bad++; $display("FAIL %s strobe_len: got %0d required %0d", name, hi, exp_hi);
    end
    n_cmp++;
    if (st !== exp_hi) begin
      n_bad++; $display("FAIL %s stall_len: got %0d required %0d", name, st, exp_hi);
    end
    n_cmp++;
    if (bus_bad !== 1'b0) begin
      n_bad++; $display("FAIL %s bus: wrong addr/data or strobe direction during access", name);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++; $display("FAIL %s err: got %b required %b", name, err, exp_err);
    end
    got_v = intdata;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL %s scoreboard: expected queue empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL %s intdata: got %h required %h", name, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd_stb, wr_stb, stall, err} !== 4'b0 || intdata !== 16'h0 ||
        bus_addr !== 8'h0 || bus_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_values: strobes/stall/err=%b%b%b%b intdata=%h addr=%h data=%h required all 0",
               rd_stb, wr_stb, stall, err, intdata, bus_addr, bus_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_err_clr(input string name);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL %s: err got %b required 0", name, err);
    end
  endtask

  task automatic test_illegal();
    rd_req = 1'b1; wr_req = 1'b1; addr = 8'h77; wdata = 16'h5555;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL illegal_err: got %b required 1", err);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({rd_stb, wr_stb, stall} !== 3'b000 || bus_addr === 8'h77) begin
        n_bad++; $display("FAIL illegal_quiet: strobes/stall=%b%b%b addr=%h required idle bus",
                          rd_stb, wr_stb, stall, bus_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_illegal();
    rd_req = 1'b1; addr = 8'h33; ext_data = 16'hDEAD;
    @(negedge clk);
    rd_req = 1'b0; ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        n_cmp++;
        if (rd_stb !== 1'b1 || stall !== 1'b1) begin
          n_bad++; $display("FAIL reset_mid_pre: rd_stb=%b stall=%b required 1 1", rd_stb, stall);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rd = 16'h0;
    n_cmp++;
    if ({rd_stb, wr_stb, stall, err} !== 4'b0 || intdata !== 16'h0) begin
      n_bad++; $display("FAIL reset_mid_post: strobes/stall/err=%b%b%b%b intdata=%h required 0",
                        rd_stb, wr_stb, stall, err, intdata);
    end
    xfer(1'b0, 8'h21, 16'hA5A5, 0, 1'b0, -1, "reset_mid_new_read");
  endtask

  task automatic test_back_to_back();
    xfer(1'b0, 8'h01, 16'h1111, 0, 1'b0, -1, "b2b_read0");
    xfer(1'b1, 8'h02, 16'h2222, 0, 1'b0, -1, "b2b_write");
    xfer(1'b0, 8'h03, 16'h3333, 0, 1'b0, -1, "b2b_read1");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      xfer(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 16'($urandom_range(65535, 0)),
           int'($urandom_range(5, 0)), 1'b0, -1, "random");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    xfer(1'b0, 8'h12, 16'hBEEF, 0, 1'b0, -1, "read_imm");
    xfer(1'b1, 8'h40, 16'h1234, 3, 1'b0, -1, "write_wait3");
    xfer(1'b0, 8'h55, 16'h0F0F, TIMEOUT, 1'b1, -1, "read_timeout");
    test_err_clr("err_clr_after_timeout");
    xfer(1'b0, 8'h66, 16'hC0DE, TIMEOUT - 1, 1'b0, -1, "read_last_cycle_ack");
    test_illegal();
    test_err_clr("err_clr_after_illegal");
    xfer(1'b0, 8'h99, 16'h7777, TIMEOUT, 1'b1, TIMEOUT - 1, "timeout_with_clr");
    test_err_clr("err_clr_after_coincident");
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
